// File: rtl/stack_ctrl.sv
// Call/data stack sequencer: turns PUSH/POP/CALL/RET/INT/RETI into stack-pointer
// strobes and memory accesses at sp_val, rejecting overflow/underflow before any side effect.
module stack_ctrl #(
  parameter int         DW          = 16,
  parameter logic [9:0] STACK_LIMIT = 10'h300
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] pc_in,
  input  logic [9:0]    sp_val,
  output logic          sp_inc,
  output logic          sp_dec,
  output logic          mem_req,
  output logic          mem_we,
  output logic [9:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic [DW-1:0] mem_rdata,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [DW-1:0] res_a,
  output logic [DW-1:0] res_b
);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RETI = 3'd5;

  typedef enum logic [2:0] {IDLE, WR, INC, RD, RD_DATA, DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    op_q;
  logic          second_q;
  logic          err_q;
  logic [1:0]    err_code_q;
  logic [DW-1:0] wdata_q, pc_q;
  logic [DW-1:0] res_a_q, res_b_q;
  logic [1:0]    chk_code;
  logic [DW-1:0] wr_word;

  // Accept-time legality check; INT's "sp >= LIMIT+1" is written as "sp > LIMIT".
  always_comb begin
    chk_code = 2'd0;
    case (op)
      OP_PUSH, OP_CALL: if (sp_val < STACK_LIMIT)  chk_code = 2'd1;
      OP_INT:           if (sp_val <= STACK_LIMIT) chk_code = 2'd1;
      OP_POP, OP_RET:   if (sp_val > 10'h3FE)      chk_code = 2'd2;
      OP_RETI:          if (sp_val > 10'h3FD)      chk_code = 2'd2;
      default:          chk_code = 2'd3;
    endcase
  end

  assign wr_word = (op_q == OP_PUSH || (op_q == OP_INT && second_q)) ? wdata_q : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    op_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (chk_code != 2'd0)                                   state_nx = DONE;
          else if (op == OP_PUSH || op == OP_CALL || op == OP_INT) state_nx = WR;
          else                                                    state_nx = INC;
        end
      end
      WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_val;
        mem_wdata = wr_word;
        if (mem_gnt) begin
          sp_dec   = 1'b1;
          state_nx = (op_q == OP_INT && !second_q) ? WR : DONE;
        end
      end
      INC: begin
        sp_inc   = 1'b1;
        state_nx = RD;
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = sp_val;
        if (mem_gnt) state_nx = RD_DATA;
      end
      RD_DATA: state_nx = (op_q == OP_RETI && !second_q) ? INC : DONE;
      DONE: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_PUSH;
      second_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      res_a_q    <= '0;
      res_b_q    <= '0;
    end else begin
      if (state == IDLE && op_valid) begin
        op_q       <= op;
        second_q   <= 1'b0;
        err_q      <= (chk_code != 2'd0);
        err_code_q <= chk_code;
      end
      if (state == WR && mem_gnt) second_q <= 1'b1;
      // RETI pops flags first, then PC; every other pop lands in res_a.
      if (state == RD_DATA) begin
        second_q <= 1'b1;
        if (op_q == OP_RETI && !second_q) res_b_q <= mem_rdata;
        else                              res_a_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && op_valid) begin
      wdata_q <= wdata;
      pc_q    <= pc_in;
    end
  end

  assign err_code = err_code_q;
  assign res_a    = res_a_q;
  assign res_b    = res_b_q;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the MCU's call/data stack. Accepts one stack operation at a time from the instruction decoder: PUSH, POP, CALL, RET, INT entry, or RETI. It issues the data-memory writes and reads at the current stack pointer and drives the `inc`/`dec` strobes of the stack-pointer register. It also detects overflow and underflow before any side effect occurs. The stack grows downward from 0x3FF; the stack-pointer register resets to 0x3FF (empty).

## Interface
- `DW`, 16: data word width (PC and flags fit in one word).
- `STACK_LIMIT`, 10'h300: lowest writable stack address; must be ≥ 1.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset (one clock; async active-low reset, fixed).
- `op_valid`  in  1  operation request.
- `op_ready`  out  1  high only in IDLE; accept = `op_valid & op_ready`.
- `op`  in  3  0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RETI; 6–7 illegal.
- `wdata`  in  DW  PUSH data; flags word for INT.
- `pc_in`  in  DW  return PC for CALL and INT.
- `sp_val`  in  10  stack-pointer register output.
- `sp_inc`  out  1  one-cycle increment strobe to the stack-pointer register.
- `sp_dec`  out  1  one-cycle decrement strobe to the stack-pointer register.
- `mem_req`  out  1  memory request; held until `mem_gnt`.
- `mem_we`  out  1  1 write, 0 read; valid while `mem_req` is high.
- `mem_addr`  out  10  always equals `sp_val` while `mem_req` is high.
- `mem_wdata`  out  DW  write data.
- `mem_gnt`  in  1  grant; the access completes in the grant cycle.
- `mem_rdata`  in  DW  read data, valid the cycle after a granted read.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; 1 = operation rejected.
- `err_code`  out  2  0 none, 1 overflow, 2 underflow, 3 illegal op.
- `res_a`  out  DW  POP data / RET PC / RETI PC; held until next `done`.
- `res_b`  out  DW  RETI flags; held until next `done`.

## Operation
- FSM states: IDLE, WR, INC, RD, RD_DATA, DONE.
- Operands (`op`, `wdata`, `pc_in`) are registered at accept.
- Word count: PUSH, POP, CALL, RET = 1; INT, RETI = 2.
- Checks happen at accept, combinationally on `sp_val`:
  - PUSH/CALL need `sp_val ≥ STACK_LIMIT`.
  - INT needs `sp_val ≥ STACK_LIMIT+1`.
  - POP/RET need `sp_val ≤ 0x3FE`.
  - RETI needs `sp_val ≤ 0x3FD`.
- Failed check or illegal op → DONE with `err=1`. No memory access, no strobe, and `res_a`/`res_b` are unchanged.
- Push word sequence (WR state):
  - `mem_req=1`, `mem_we=1`, address `sp_val`.
  - In the grant cycle, `sp_dec=1`.
  - More words remain → stay in WR for the next word; otherwise → DONE.
  - PUSH writes `wdata`; CALL writes `pc_in`; INT writes `pc_in`, then `wdata`.
- Pop word sequence:
  - INC: `sp_inc=1` for one cycle → RD.
  - RD: `mem_req=1`, `mem_we=0` at the updated `sp_val`; on grant → RD_DATA.
  - RD_DATA: capture `mem_rdata`. More words remain → INC; otherwise → DONE.
  - POP and RET load `res_a`. RETI loads `res_b` (flags) first, then `res_a` (PC).
- DONE: `done=1` for one cycle → IDLE.
- `sp_inc` and `sp_dec` are never high together. Neither is ever high outside INC or a granted WR cycle.
- The stack-pointer value never wraps; the checks guarantee this.

## Timing
- Reset values: all outputs 0 except `op_ready=1`; state IDLE; `res_a`, `res_b`, `err_code` = 0.
- Reset mid-operation aborts immediately: no further strobes or requests. The stack-pointer register resets on the same `rst_n`.
- Latency from the accept cycle T, assuming `mem_gnt` is already high:
  - PUSH/CALL: `sp_dec` at T+1, `done` at T+2, `op_ready` at T+3.
  - INT: `sp_dec` at T+1 and T+2, `done` at T+3.
  - POP/RET: `sp_inc` at T+1, read at T+2, `done` at T+4.
  - RETI: `done` at T+7.
  - Error: `done` at T+1.
- Each cycle of `mem_gnt=0` adds one cycle. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable while stalled.
- `op_valid` outside IDLE is ignored; the requester holds the request until accepted.

## Test plan
- Reset, PUSH `wdata=0xBEEF`: write at 0x3FF, `sp_val`→0x3FE, `done` at T+2. Then POP: read at 0x3FF, `res_a=0xBEEF`, `sp_val`→0x3FF.
- INT with `pc_in=0x0123`, `wdata=0x00A5`: writes 0x3FF←0x0123, 0x3FE←0x00A5. Then RETI: `res_b=0x00A5`, `res_a=0x0123`, `sp_val`=0x3FF.
- POP, RET, or RETI straight after reset: `done` at T+1, `err=1`, `err_code=2`, no `mem_req`, `sp_val` stays 0x3FF.
- `STACK_LIMIT=0x3FE`: two PUSHes succeed, third gives `err_code=1`. At `sp_val=0x3FE`, INT is rejected with no write.
- `mem_gnt` held low 3 cycles during a CALL: request stable throughout, single `sp_dec`, `done` at T+5. Illegal `op=7` gives `err_code=3`.
- `rst_n` asserted during RD of a RETI: outputs return to reset values immediately, `sp_val`=0x3FF, next PUSH behaves as in the first scenario.
